// File: rtl/board_io_pkg.sv
// Shared defaults and helpers for the board I/O conditioner.
package board_io_pkg;

    // 10 ms stability window at a 6 MHz board clock.
    localparam int unsigned DefDebounceCycles = 60000;
    localparam int unsigned DefPwmWidth       = 4;

    // Width of a counter that must reach DebounceCycles-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/board_io_debounce.sv
// One button channel: polarity fix-up, two-flop synchroniser, debounce window,
// stable level and one-cycle press/release pulses.
module board_io_debounce
    import board_io_pkg::*;
#(
    parameter bit          ActiveLow      = 1'b0,
    parameter int unsigned DebounceCycles = DefDebounceCycles
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int unsigned     CntW   = cnt_width(DebounceCycles);
    localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);

    logic            pressed;
    logic            s1_q, s2_q;
    logic            stable_q, stable_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            rise_q, rise_d;
    logic            fall_q, fall_d;

    assign pressed = pin ^ ActiveLow;

    // Accept s2 only after it has differed from the stable level for the full window;
    // any return to the stable level restarts the window.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        if (s2_q != stable_q) begin
            if (cnt_q == CntMax) begin
                stable_d = s2_q;
                rise_d   = s2_q;
                fall_d   = ~s2_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    // Synchroniser, debounce state and registered pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            s1_q     <= pressed;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign level = stable_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/board_io_ctrl.sv
// Board I/O conditioner: debounced buttons with edge events, PWM-dimmed LEDs.
module board_io_ctrl
    import board_io_pkg::*;
#(
    parameter int unsigned       NumBtn         = 3,
    parameter int unsigned       NumLed         = 5,
    parameter logic [NumBtn-1:0] BtnActiveLow   = '0,
    parameter int unsigned       DebounceCycles = DefDebounceCycles,
    parameter int unsigned       PwmWidth       = DefPwmWidth
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NumBtn-1:0]          btn_i,
    output logic [NumBtn-1:0]          btn_o,
    output logic [NumBtn-1:0]          btn_rise_o,
    output logic [NumBtn-1:0]          btn_fall_o,
    input  logic [NumLed-1:0]          led_en_i,
    input  logic [NumLed*PwmWidth-1:0] led_duty_i,
    output logic [NumLed-1:0]          led_o
);

    for (genvar i = 0; i < NumBtn; i++) begin : g_btn
        board_io_debounce #(
            .ActiveLow      (BtnActiveLow[i]),
            .DebounceCycles (DebounceCycles)
        ) u_debounce (
            .clk   (clk_i),
            .rst   (rst_i),
            .pin   (btn_i[i]),
            .level (btn_o[i]),
            .rise  (btn_rise_o[i]),
            .fall  (btn_fall_o[i])
        );
    end

    logic [PwmWidth-1:0] pwm_cnt_q;
    logic [PwmWidth-1:0] duty [NumLed];
    logic [NumLed-1:0]   led_d, led_q;

    for (genvar i = 0; i < NumLed; i++) begin : g_duty
        assign duty[i] = led_duty_i[i*PwmWidth +: PwmWidth];
    end

    // All-ones duty is forced fully on; otherwise the shared counter gives d high cycles
    // out of every 2^PwmWidth.
    always_comb begin
        led_d = '0;
        for (int i = 0; i < NumLed; i++) begin
            led_d[i] = led_en_i[i] & ((&duty[i]) | (pwm_cnt_q < duty[i]));
        end
    end

    // Free-running PWM counter and registered LED drive.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pwm_cnt_q <= '0;
            led_q     <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + PwmWidth'(1);
            led_q     <= led_d;
        end
    end

    assign led_o = led_q;

endmodule

// File: tb/tb_board_io_ctrl.sv
// Scoreboard bench for board_io_ctrl: the driver pushes the expected outputs for every
// clock edge from a time-based reference model; a monitor pops and compares after each edge.
module tb_board_io_ctrl;

    localparam int NB  = 3;
    localparam int NL  = 5;
    localparam int DEB = 4;
    localparam int PW  = 4;
    localparam logic [NB-1:0] ACT_LOW = 3'b001;

    logic              clk = 1'b0;
    logic              rst;
    logic [NB-1:0]     btn;
    logic [NB-1:0]     btn_o, btn_rise_o, btn_fall_o;
    logic [NL-1:0]     en;
    logic [NL*PW-1:0]  duty;
    logic [NL-1:0]     led_o;

    int checks   = 0;
    int failures = 0;

    board_io_ctrl #(
        .NumBtn         (NB),
        .NumLed         (NL),
        .BtnActiveLow   (ACT_LOW),
        .DebounceCycles (DEB),
        .PwmWidth       (PW)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .btn_i      (btn),
        .btn_o      (btn_o),
        .btn_rise_o (btn_rise_o),
        .btn_fall_o (btn_fall_o),
        .led_en_i   (en),
        .led_duty_i (duty),
        .led_o      (led_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NB-1:0] btn;
        logic [NB-1:0] rise;
        logic [NB-1:0] fall;
        logic [NL-1:0] led;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    // Reference model state: edges since reset release, pressed-value history,
    // accepted level and length of the current run of identical synchronised values.
    int t;
    bit hist[NB][$];
    bit stable[NB];
    bit run_val[NB];
    int run_len[NB];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        t = 0;
        for (int c = 0; c < NB; c++) begin
            hist[c].delete();
            hist[c].push_back(1'b0);
            hist[c].push_back(1'b0);
            stable[c]  = 1'b0;
            run_val[c] = 1'b0;
            run_len[c] = 0;
        end
    endtask

    // Predict the outputs after the coming edge from the current inputs, then advance.
    task automatic tick();
        exp_t e;
        bit   p, seen;
        logic [PW-1:0] d;
        e = '0;
        if (rst) begin
            model_reset();
        end else begin
            for (int c = 0; c < NB; c++) begin
                p    = btn[c] ^ ACT_LOW[c];
                seen = hist[c].pop_front();
                hist[c].push_back(p);
                if (seen == run_val[c]) begin
                    run_len[c]++;
                end else begin
                    run_val[c] = seen;
                    run_len[c] = 1;
                end
                if (seen != stable[c] && run_len[c] >= DEB) begin
                    stable[c] = seen;
                    if (seen) e.rise[c] = 1'b1;
                    else      e.fall[c] = 1'b1;
                end
                e.btn[c] = stable[c];
            end
            for (int l = 0; l < NL; l++) begin
                d = duty[l*PW +: PW];
                e.led[l] = en[l] && (d == 4'hF || (t % 16) < int'(d));
            end
            t++;
        end
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Count edges from the first sampling edge until the requested pulse on a channel.
    task automatic measure(input int ch, input bit want_rise, output int lat);
        lat = -1;
        for (int n = 1; n <= 12; n++) begin
            tick();
            if (lat < 0 && (want_rise ? btn_rise_o[ch] : btn_fall_o[ch])) lat = n;
        end
    endtask

    task automatic pwm_run(input int ch, input bit e_, input int dv, output int cnt);
        en[ch] = e_;
        duty[ch*PW +: PW] = PW'(dv);
        cnt = 0;
        repeat (32) begin
            tick();
            cnt += int'(led_o[ch]);
        end
    endtask

    // Monitor: one expected entry per edge.
    always @(posedge clk) begin
        #1;
        if (sb.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
        end else begin
            mon_e = sb.pop_front();
            check("btn_o",      32'(btn_o),      32'(mon_e.btn));
            check("btn_rise_o", 32'(btn_rise_o), 32'(mon_e.rise));
            check("btn_fall_o", 32'(btn_fall_o), 32'(mon_e.fall));
            check("led_o",      32'(led_o),      32'(mon_e.led));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, cnt, pulses, falls, first_n;
        logic [NB-1:0] first_v;

        rst  = 1'b1;
        btn  = 3'b000;   // channel 0 is active-low, so it reads as pressed
        en   = '0;
        duty = '0;
        repeat (3) tick();
        check("reset_outputs", 32'({btn_o, btn_rise_o, btn_fall_o, led_o}), 32'd0);

        en   = '1;
        duty = NL*PW'($urandom);
        rst  = 1'b0;
        measure(0, 1'b1, lat);
        check("boot_rise_latency", 32'(lat), 32'd6);

        btn[2] = 1'b1;
        measure(2, 1'b1, lat);
        check("press_latency", 32'(lat), 32'd6);
        check("press_level", 32'(btn_o[2]), 32'd1);

        // Bounce 1,0,1 at two-cycle intervals, then hold pressed.
        pulses = 0;
        falls  = 0;
        for (int i = 0; i < 16; i++) begin
            btn[1] = (i < 2) ? 1'b1 : (i < 4) ? 1'b0 : 1'b1;
            tick();
            pulses += int'(btn_rise_o[1]);
            falls  += int'(btn_fall_o[1]);
        end
        check("bounce_rise_count", 32'(pulses), 32'd1);
        check("bounce_fall_count", 32'(falls), 32'd0);

        btn[0] = 1'b1;   // active-low release
        measure(0, 1'b0, lat);
        check("release_fall_latency", 32'(lat), 32'd6);
        check("release_level", 32'(btn_o[0]), 32'd0);

        pwm_run(2, 1'b1, 4, cnt);
        check("pwm_duty4", 32'(cnt), 32'd8);
        pwm_run(2, 1'b1, 15, cnt);
        check("pwm_duty15", 32'(cnt), 32'd32);
        pwm_run(2, 1'b1, 0, cnt);
        check("pwm_duty0", 32'(cnt), 32'd0);
        pwm_run(2, 1'b0, 8, cnt);
        check("pwm_disabled", 32'(cnt), 32'd0);
        en[2] = 1'b1;

        // Reset after two counted cycles of a press.
        btn = 3'b001;
        repeat (10) tick();
        btn[2] = 1'b1;
        repeat (4) tick();
        rst = 1'b1;
        repeat (2) tick();
        check("midreset_outputs", 32'({btn_o, btn_rise_o, btn_fall_o, led_o}), 32'd0);
        rst = 1'b0;
        measure(2, 1'b1, lat);
        check("midreset_latency", 32'(lat), 32'd6);

        // All buttons pressed on one edge; LEDs at independent duties.
        btn = 3'b001;
        repeat (10) tick();
        duty[0*PW +: PW] = 4'd1;
        duty[1*PW +: PW] = 4'd8;
        duty[2*PW +: PW] = 4'd15;
        btn = 3'b110;
        first_n = -1;
        first_v = '0;
        for (int n = 1; n <= 12; n++) begin
            tick();
            if (first_n < 0 && btn_rise_o != '0) begin
                first_n = n;
                first_v = btn_rise_o;
            end
        end
        check("multi_rise_bits", 32'(first_v), 32'd7);
        check("multi_rise_latency", 32'(first_n), 32'd6);
        repeat (16) tick();

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(7) == 0) begin
                int idx;
                idx = int'($urandom_range(NB - 1));
                btn[idx] = ~btn[idx];
            end
            if ($urandom_range(15) == 0) begin
                duty = NL*PW'($urandom);
                en   = NL'($urandom);
            end
            rst = ($urandom_range(149) == 0);
            tick();
        end
        rst = 1'b0;
        tick();

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
